// File: rtl/logic_exec_pipe_if.sv
// Issue-side and writeback-side handshake bundle for logic_exec_pipe.
// master: the producer/consumer environment; slave: the execution unit.
interface logic_exec_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 12,
    parameter int TAG_WIDTH  = 5
);
    // Issue side
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            logic_type;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [IMM_WIDTH-1:0]  immediate;
    logic [TAG_WIDTH-1:0]  in_tag;

    // Writeback side
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_illegal;

    modport master (
        output in_valid, logic_type, src1, src2, immediate, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, logic_type, src1, src2, immediate, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );
endinterface

// File: rtl/logic_exec_pipe.sv
// Pipelined RV32I logical execution unit (XOR/OR/AND/ANDN and immediate forms).
// The result is computed in the accept cycle and then carried with its tag and
// illegal flag through PIPE_STAGES elastic register slots. Each slot advances
// when the slot ahead of it is empty or itself advancing, so bubbles collapse
// under backpressure and a full pipe still sustains one op per cycle.
module logic_exec_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int IMM_WIDTH   = 12,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    logic_exec_pipe_if.slave    bus
);

    localparam int LAST = PIPE_STAGES - 1;

    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ANDN = 3'b011;
    localparam logic [2:0] OP_ILL  = 3'b100;
    localparam logic [2:0] OP_ANDI = 3'b101;
    localparam logic [2:0] OP_ORI  = 3'b110;
    localparam logic [2:0] OP_XORI = 3'b111;

    // Logical operation on the already-selected second operand; the illegal
    // encoding yields zero.
    function automatic logic [DATA_WIDTH-1:0] exec_logic(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_XOR, OP_XORI: r = a ^ b;
            OP_OR,  OP_ORI:  r = a | b;
            OP_AND, OP_ANDI: r = a & b;
            OP_ANDN:         r = a & ~b;
            default:         r = '0;
        endcase
        return r;
    endfunction

    // Per-slot state; index 0 is stage 1, index LAST drives the outputs.
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] illegal_q;
    logic [PIPE_STAGES-1:0] illegal_d;
    logic [DATA_WIDTH-1:0]  data_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  data_d [PIPE_STAGES];
    logic [TAG_WIDTH-1:0]   tag_q  [PIPE_STAGES];
    logic [TAG_WIDTH-1:0]   tag_d  [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] move_s;       // slot k hands its op onward this cycle
    logic [PIPE_STAGES-1:0] valid_shift_s; // valid bits after shifting, before flush
    logic                   in_ready_s;
    logic                   accept_s;
    logic [DATA_WIDTH-1:0]  imm_ext_s;
    logic [DATA_WIDTH-1:0]  operand2_s;
    logic [DATA_WIDTH-1:0]  result_s;
    logic                   illegal_s;

    // Operand select and result computation for the op presented this cycle.
    assign imm_ext_s  = {{(DATA_WIDTH-IMM_WIDTH){bus.immediate[IMM_WIDTH-1]}}, bus.immediate};
    assign operand2_s = bus.logic_type[2] ? imm_ext_s : bus.src2;
    assign result_s   = exec_logic(bus.logic_type, bus.src1, operand2_s);
    assign illegal_s  = (bus.logic_type == OP_ILL);

    // Advance chain, resolved from the output slot back toward stage 1.
    always_comb begin
        move_s       = '0;
        move_s[LAST] = valid_q[LAST] & bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            move_s[k] = valid_q[k] & (~valid_q[k+1] | move_s[k+1]);
        end
    end

    // Stage 1 can take a new op when empty or when its occupant moves on.
    assign in_ready_s = ~valid_q[0] | move_s[0];
    assign accept_s   = bus.in_valid & in_ready_s & ~flush;

    // Next-state for all slots; payload only changes when a slot is loaded,
    // so a stalled output slot holds its data, tag and flag stable.
    always_comb begin
        valid_shift_s = valid_q;
        illegal_d     = illegal_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            data_d[k] = data_q[k];
            tag_d[k]  = tag_q[k];
        end

        if (accept_s) begin
            valid_shift_s[0] = 1'b1;
            data_d[0]        = result_s;
            tag_d[0]         = bus.in_tag;
            illegal_d[0]     = illegal_s;
        end else if (move_s[0]) begin
            valid_shift_s[0] = 1'b0;
        end else begin
            valid_shift_s[0] = valid_q[0];
        end

        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (move_s[k-1]) begin
                valid_shift_s[k] = 1'b1;
                data_d[k]        = data_q[k-1];
                tag_d[k]         = tag_q[k-1];
                illegal_d[k]     = illegal_q[k-1];
            end else if (move_s[k]) begin
                valid_shift_s[k] = 1'b0;
            end else begin
                valid_shift_s[k] = valid_q[k];
            end
        end

        // Flush kills every in-flight op; payload registers may keep stale data.
        valid_d = flush ? '0 : valid_shift_s;
    end

    // Slot registers with synchronous reset clearing valid and payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            illegal_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    // Outputs come straight from the last slot's registers.
    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = valid_q[LAST];
    assign bus.out_data    = data_q[LAST];
    assign bus.out_tag     = tag_q[LAST];
    assign bus.out_illegal = illegal_q[LAST];

endmodule

// File: tb/tb_logic_exec_pipe.sv
// Directed self-checking bench for logic_exec_pipe: a 2-stage instance for the
// functional, backpressure, illegal and flush cases and a 4-stage instance for
// the mid-stream reset case.
module tb_logic_exec_pipe;

    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ANDN = 3'b011;
    localparam logic [2:0] OP_ILL  = 3'b100;
    localparam logic [2:0] OP_ANDI = 3'b101;
    localparam logic [2:0] OP_ORI  = 3'b110;
    localparam logic [2:0] OP_XORI = 3'b111;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int checks = 0;
    int errors = 0;

    logic_exec_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(12), .TAG_WIDTH(5)) ifc2 ();
    logic_exec_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(12), .TAG_WIDTH(5)) ifc4 ();

    logic_exec_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(12), .PIPE_STAGES(2), .TAG_WIDTH(5)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (ifc2)
    );

    logic_exec_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(12), .PIPE_STAGES(4), .TAG_WIDTH(5)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .bus   (ifc4)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    logic [2:0]  reg_op  [4] = '{OP_XOR, OP_OR, OP_AND, OP_ANDN};
    logic [31:0] reg_exp [4] = '{32'hAAAA_AAAA, 32'hAFAF_AFAF, 32'h0505_0505, 32'hA0A0_A0A0};
    logic [31:0] bp_src  [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'h4444_4444, 32'h5555_5555};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive2(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] imm, input logic [4:0] tag);
        ifc2.in_valid   = 1'b1;
        ifc2.logic_type = op;
        ifc2.src1       = a;
        ifc2.src2       = b;
        ifc2.immediate  = imm;
        ifc2.in_tag     = tag;
    endtask

    task automatic drive4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] imm, input logic [4:0] tag);
        ifc4.in_valid   = 1'b1;
        ifc4.logic_type = op;
        ifc4.src1       = a;
        ifc4.src2       = b;
        ifc4.immediate  = imm;
        ifc4.in_tag     = tag;
    endtask

    initial begin
        int  acc;
        int  nout;
        logic acc_now;

        reset = 1'b1;
        flush = 1'b0;
        ifc2.in_valid = 1'b0; ifc2.out_ready = 1'b1; ifc2.logic_type = 3'b000;
        ifc2.src1 = 32'h0; ifc2.src2 = 32'h0; ifc2.immediate = 12'h0; ifc2.in_tag = 5'h0;
        ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b1; ifc4.logic_type = 3'b000;
        ifc4.src1 = 32'h0; ifc4.src2 = 32'h0; ifc4.immediate = 12'h0; ifc4.in_tag = 5'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        reset = 1'b0;
        settle();
        check_val("rst_out_valid",   32'(ifc2.out_valid),   32'h0);
        check_val("rst_out_data",    ifc2.out_data,         32'h0);
        check_val("rst_out_tag",     32'(ifc2.out_tag),     32'h0);
        check_val("rst_out_illegal", 32'(ifc2.out_illegal), 32'h0);
        check_val("rst_in_ready",    32'(ifc2.in_ready),    32'h1);
        check_val("rst4_out_valid",  32'(ifc4.out_valid),   32'h0);

        // ---------------- immediate forms ----------------
        tick(); drive2(OP_ANDI, 32'h0000_FFFF, 32'h0, 12'hF00, 5'd1); settle();
        check_val("imm_in_ready", 32'(ifc2.in_ready), 32'h1);
        tick(); drive2(OP_ORI,  32'h0000_FFFF, 32'h0, 12'hF00, 5'd2); settle();
        check_val("andi_early", 32'(ifc2.out_valid), 32'h0);
        tick(); drive2(OP_XORI, 32'h0000_FFFF, 32'h0, 12'hF00, 5'd3); settle();
        check_val("andi_valid", 32'(ifc2.out_valid), 32'h1);
        check_val("andi_data",  ifc2.out_data, 32'h0000_FF00);
        check_val("andi_tag",   32'(ifc2.out_tag), 32'd1);
        tick(); ifc2.in_valid = 1'b0; settle();
        check_val("ori_data", ifc2.out_data, 32'hFFFF_FFFF);
        check_val("ori_tag",  32'(ifc2.out_tag), 32'd2);
        tick(); settle();
        check_val("xori_data", ifc2.out_data, 32'hFFFF_00FF);
        check_val("xori_tag",  32'(ifc2.out_tag), 32'd3);
        tick(); settle();
        check_val("imm_drain", 32'(ifc2.out_valid), 32'h0);

        // ---------------- register forms, back to back ----------------
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 4) drive2(reg_op[i], 32'hA5A5_A5A5, 32'h0F0F_0F0F, 12'h0, 5'(i + 1));
            else       ifc2.in_valid = 1'b0;
            settle();
            if (i < 2 || i > 5) begin
                check_val("reg_idle_valid", 32'(ifc2.out_valid), 32'h0);
            end else begin
                check_val("reg_valid", 32'(ifc2.out_valid), 32'h1);
                check_val("reg_data",  ifc2.out_data, reg_exp[i-2]);
                check_val("reg_tag",   32'(ifc2.out_tag), 32'(i - 1));
            end
        end

        // ---------------- backpressure ----------------
        acc = 0; nout = 0; acc_now = 1'b0;
        for (int c = 0; c < 40 && nout < 5; c++) begin
            tick();
            if (acc_now) acc++;
            if (acc < 5) drive2(OP_OR, bp_src[acc], 32'h0, 12'h0, 5'(acc + 1));
            else         ifc2.in_valid = 1'b0;
            ifc2.out_ready = (c >= 6);
            settle();
            if (c == 2) check_val("bp_in_ready_full", 32'(ifc2.in_ready), 32'h0);
            if (c >= 2 && c <= 5) begin
                check_val("bp_hold_data", ifc2.out_data, bp_src[0]);
                check_val("bp_hold_tag",  32'(ifc2.out_tag), 32'd1);
            end
            if (c == 5) check_val("bp_accepts_stalled", 32'(acc), 32'd2);
            if (ifc2.out_valid && ifc2.out_ready) begin
                check_val("bp_out_data", ifc2.out_data, bp_src[nout]);
                check_val("bp_out_tag",  32'(ifc2.out_tag), 32'(nout + 1));
                nout++;
            end
            acc_now = ifc2.in_valid & ifc2.in_ready;
        end
        check_val("bp_out_count", 32'(nout), 32'd5);
        tick(); ifc2.in_valid = 1'b0; settle();
        check_val("bp_no_dup", 32'(ifc2.out_valid), 32'h0);

        // ---------------- illegal opcode ----------------
        ifc2.out_ready = 1'b1;
        tick(); drive2(OP_ILL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'hFFF, 5'd7); settle();
        tick(); ifc2.in_valid = 1'b0; settle();
        check_val("ill_early", 32'(ifc2.out_valid), 32'h0);
        tick(); settle();
        check_val("ill_valid", 32'(ifc2.out_valid),   32'h1);
        check_val("ill_flag",  32'(ifc2.out_illegal), 32'h1);
        check_val("ill_data",  ifc2.out_data,         32'h0);
        check_val("ill_tag",   32'(ifc2.out_tag),     32'd7);

        // ---------------- flush ----------------
        tick(); drive2(OP_XOR, 32'h1, 32'h2, 12'h0, 5'd10); settle();
        tick(); drive2(OP_OR,  32'h4, 32'h8, 12'h0, 5'd11); settle();
        tick(); drive2(OP_AND, 32'hFFFF_FFFF, 32'h1234_5678, 12'h0, 5'd12); flush = 1'b1; settle();
        check_val("flush_cycle_tag",  32'(ifc2.out_tag), 32'd10);
        check_val("flush_cycle_data", ifc2.out_data,     32'h3);
        tick(); flush = 1'b0; ifc2.in_valid = 1'b0; settle();
        check_val("flush_in_ready", 32'(ifc2.in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check_val("flush_out_valid", 32'(ifc2.out_valid), 32'h0);
        end

        // ---------------- reset mid-stream, 4 stages ----------------
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive4((i == 0) ? OP_ILL : OP_AND, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 12'h0, 5'(9 + i));
            settle();
            check_val("p4_fill_ready", 32'(ifc4.in_ready), 32'h1);
        end
        tick(); settle();
        check_val("p4_full_ready", 32'(ifc4.in_ready),    32'h0);
        check_val("p4_full_valid", 32'(ifc4.out_valid),   32'h1);
        check_val("p4_full_tag",   32'(ifc4.out_tag),     32'd9);
        check_val("p4_full_ill",   32'(ifc4.out_illegal), 32'h1);
        tick(); reset = 1'b1; settle();
        tick(); reset = 1'b0; ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b1; settle();
        check_val("p4_rst_valid", 32'(ifc4.out_valid),   32'h0);
        check_val("p4_rst_data",  ifc4.out_data,         32'h0);
        check_val("p4_rst_tag",   32'(ifc4.out_tag),     32'h0);
        check_val("p4_rst_ill",   32'(ifc4.out_illegal), 32'h0);
        check_val("p4_rst_ready", 32'(ifc4.in_ready),    32'h1);
        tick(); drive4(OP_XOR, 32'hFFFF_FFFF, 32'h0000_0001, 12'h0, 5'd3); settle();
        for (int i = 1; i <= 4; i++) begin
            tick(); ifc4.in_valid = 1'b0; settle();
            if (i < 4) begin
                check_val("p4_latency", 32'(ifc4.out_valid), 32'h0);
            end else begin
                check_val("p4_valid", 32'(ifc4.out_valid), 32'h1);
                check_val("p4_data",  ifc4.out_data,       32'hFFFF_FFFE);
                check_val("p4_tag",   32'(ifc4.out_tag),   32'd3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_exec_pipe.md
Name: logic_exec_pipe

Overview:
- Parametrised, pipelined successor to the integer logical execution unit.
- Executes RV32I logical ops XOR/OR/AND/XORI/ORI/ANDI plus ANDN with a valid/ready handshake, configurable pipeline depth, destination-tag passthrough and flush.
- Sits between issue and writeback in the execution cluster.
- Captures opcode and operands together, so result and opcode never come from different instructions.

Parameters:
- DATA_WIDTH, 32, operand/result width
- IMM_WIDTH, 12, immediate width; sign-extended to DATA_WIDTH
- PIPE_STAGES, 2, register stages from input to output, legal 1..4
- TAG_WIDTH, 5, destination-register tag carried alongside the op

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  kill all in-flight ops (branch mispredict)
- in_valid  input  1  input op valid
- in_ready  output  1  unit accepts op this cycle
- logic_type  input  3  opcode
- src1  input  DATA_WIDTH  rs1 value
- src2  input  DATA_WIDTH  rs2 value
- immediate  input  IMM_WIDTH  I-type immediate
- in_tag  input  TAG_WIDTH  destination tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  DATA_WIDTH  result
- out_tag  output  TAG_WIDTH  tag of result
- out_illegal  output  1  opcode was illegal

Behaviour:
- Opcodes:
  - 000 XOR, 001 OR, 010 AND, 011 ANDN (src1 & ~src2).
  - 101 ANDI, 110 ORI, 111 XORI.
  - 100 illegal.
- Operand select: logic_type[2]=1 selects the sign-extended immediate as the second operand: {{(DATA_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate}. Otherwise src2 is used.
- Illegal opcode 100: result 0, out_illegal=1. The op still flows through the pipe and still needs a handshake.
- Accept: an input op is accepted on a clk edge when in_valid & in_ready & !flush.
- Stage 1 update: on accept, stage 1 loads result, tag, illegal flag and valid=1. The result is computed combinationally from inputs in the accept cycle.
- Stage structure:
  - Stages 1..PIPE_STAGES each hold {valid, data, tag, illegal}.
  - The output is the last stage.
  - Stage k advances into k+1 when k+1 is empty or k+1 is itself advancing.
  - The last stage advances when out_ready=1.
- in_ready = !valid[1] | stage-1-advancing. It is combinational from out_ready through the pipe. in_ready does not depend on in_valid.
- Latency: exactly PIPE_STAGES cycles from accept to out_valid with no backpressure.
- Throughput: one op per cycle sustained.
- Backpressure: while out_valid & !out_ready, out_data, out_tag and out_illegal hold stable. No op is dropped or duplicated. Bubbles collapse: a stalled last stage still lets earlier empty slots fill. When all stages are full and out_ready=0, in_ready=0.
- Flush:
  - All stage valid bits clear at the next edge.
  - An input presented in the flush cycle is discarded.
  - out_valid=0 the cycle after flush.
  - An output handshake occurring in the flush cycle still counts as delivered.
- Reset: all valid bits, data, tag and illegal registers clear to 0. After reset, out_valid=0, out_data=0, out_tag=0, out_illegal=0, and in_ready=1 the cycle after reset deasserts. Reset mid-stream drops all ops. Reset overrides flush and in_valid.
- Data registers need not clear on flush; only valid bits must clear.
- Simultaneous full-pipe accept and out_ready: the pipe shifts and accepts in the same cycle, with occupancy unchanged.

Test Plan:
- Immediate forms, PIPE_STAGES=2, out_ready=1: src1=0x0000_FFFF, imm=0xF00 (sign-extends to 0xFFFF_FF00).
  - ANDI gives 0x0000_FF00 exactly 2 cycles after accept.
  - ORI gives 0xFFFF_FFFF.
  - XORI gives 0xFFFF_00FF.
- Register forms and ANDN, back-to-back with tags 1..4: src1=0xA5A5_A5A5, src2=0x0F0F_0F0F.
  - XOR gives 0xAAAA_AAAA.
  - OR gives 0xAFAF_AFAF.
  - AND gives 0x0505_0505.
  - ANDN gives 0xA0A0_A0A0.
  - Results appear on 4 consecutive cycles with tags 1..4 in order.
- Backpressure:
  - Hold out_ready=0 while streaming 5 ops: in_ready drops after 2 accepts, and out_data holds the first result stable.
  - Release out_ready: all 5 results emerge in order, with no loss and no duplication.
- Illegal opcode: logic_type=100, tag=7 gives out_valid=1, out_illegal=1, out_data=0, out_tag=7, after 2 cycles.
- Flush: with 2 ops in flight, assert flush together with a new in_valid op.
  - out_valid=0 on the following cycles.
  - The new op is never output.
  - in_ready=1 the next cycle.
- Reset mid-stream with PIPE_STAGES=4 and the pipe full:
  - The cycle after reset, all outputs are 0.
  - A subsequent op (XOR 0xFFFF_FFFF, 0x1) gives 0xFFFF_FFFE after 4 cycles.
